// File: rtl/mem_pkg.sv
// Shared types and encodings for the memory request scheduler slice.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_IF_WAIT = 3'd1,
    ST_LD_WAIT = 3'd2,
    ST_ST_WAIT = 3'd3,
    ST_GAP     = 3'd4
  } sched_state_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  localparam int unsigned CNT_W_DEF      = 3;
  localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_grant_arbiter.sv
// LSB-first arbiter with a starvation bound that forces a fetch grant
// after STARVE_MAX consecutive LSB grants while fetch is waiting.
module mem_grant_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic arb_en,
  input  logic if_req,
  input  logic ls_req,
  output logic gnt_if,
  output logic gnt_ls
);

  logic [CNT_W-1:0] cnt;

  // Priority decision: LSB wins unless fetch has been starved too long.
  always_comb begin
    gnt_ls = arb_en && ls_req && (!if_req || (cnt < CNT_W'(STARVE_MAX)));
    gnt_if = arb_en && if_req && !gnt_ls;
  end

  // Starvation counter: counts LSB grants taken over a waiting fetch.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (rdy_in) begin
      if (gnt_ls) begin
        if (!if_req)
          cnt <= '0;
        else if (cnt != CNT_W'(STARVE_MAX))
          cnt <= cnt + 1'b1;
      end else if (gnt_if) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// Single-outstanding request scheduler between fetch/LSB and the memory
// controller; latches the granted request and returns results with an ack.
module mem_req_scheduler
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_signal,
  input  logic        if_req,
  input  logic [31:0] if_a,
  output logic        if_ack,
  output logic [63:0] if_d,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic        ls_signed,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_a,
  input  logic [31:0] ls_din,
  output logic        ls_ack,
  output logic [31:0] ls_dout,
  output logic        instr_signal,
  output logic [31:0] instr_a,
  input  logic [63:0] instr_d,
  input  logic        instr_done,
  output logic        lsb_signal,
  output logic        lsb_wr,
  output logic        lsb_signed,
  output logic [1:0]  lsb_len,
  output logic [31:0] lsb_a,
  output logic [31:0] lsb_din,
  input  logic [31:0] lsb_dout,
  input  logic        lsb_done,
  output logic        busy
);

  sched_state_t state, state_nxt;

  logic        gnt_if, gnt_ls;
  logic        if_ack_nxt, ls_ack_nxt;
  logic [63:0] if_d_nxt;
  logic [31:0] ls_dout_nxt;
  logic        instr_signal_nxt, lsb_signal_nxt;
  logic [31:0] instr_a_nxt, lsb_a_nxt, lsb_din_nxt;
  logic        lsb_wr_nxt, lsb_signed_nxt;
  logic [1:0]  lsb_len_nxt;

  mem_grant_arbiter #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_arb (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .arb_en ((state == ST_IDLE) && !clear_signal),
    .if_req (if_req),
    .ls_req (ls_req),
    .gnt_if (gnt_if),
    .gnt_ls (gnt_ls)
  );

  assign busy = (state != ST_IDLE);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt        = state;
    if_ack_nxt       = 1'b0;
    ls_ack_nxt       = 1'b0;
    if_d_nxt         = if_d;
    ls_dout_nxt      = ls_dout;
    instr_signal_nxt = instr_signal;
    instr_a_nxt      = instr_a;
    lsb_signal_nxt   = lsb_signal;
    lsb_wr_nxt       = lsb_wr;
    lsb_signed_nxt   = lsb_signed;
    lsb_len_nxt      = lsb_len;
    lsb_a_nxt        = lsb_a;
    lsb_din_nxt      = lsb_din;
    unique case (state)
      ST_IDLE: begin
        if (gnt_ls) begin
          lsb_signal_nxt = 1'b1;
          lsb_wr_nxt     = ls_wr;
          lsb_signed_nxt = ls_signed;
          lsb_len_nxt    = ls_len;
          lsb_a_nxt      = ls_a;
          lsb_din_nxt    = ls_din;
          state_nxt      = ls_wr ? ST_ST_WAIT : ST_LD_WAIT;
        end else if (gnt_if) begin
          instr_signal_nxt = 1'b1;
          instr_a_nxt      = if_a;
          state_nxt        = ST_IF_WAIT;
        end
      end
      ST_IF_WAIT: begin
        if (clear_signal) begin
          instr_signal_nxt = 1'b0;
          state_nxt        = ST_GAP;
        end else if (instr_done) begin
          if_d_nxt         = instr_d;
          if_ack_nxt       = 1'b1;
          instr_signal_nxt = 1'b0;
          state_nxt        = ST_GAP;
        end
      end
      ST_LD_WAIT: begin
        if (clear_signal) begin
          lsb_signal_nxt = 1'b0;
          state_nxt      = ST_GAP;
        end else if (lsb_done) begin
          ls_dout_nxt    = lsb_dout;
          ls_ack_nxt     = 1'b1;
          lsb_signal_nxt = 1'b0;
          state_nxt      = ST_GAP;
        end
      end
      ST_ST_WAIT: begin
        if (lsb_done) begin
          ls_ack_nxt     = 1'b1;
          lsb_signal_nxt = 1'b0;
          state_nxt      = ST_GAP;
        end
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= ST_IDLE;
      if_ack       <= 1'b0;
      if_d         <= '0;
      ls_ack       <= 1'b0;
      ls_dout      <= '0;
      instr_signal <= 1'b0;
      instr_a      <= '0;
      lsb_signal   <= 1'b0;
      lsb_wr       <= 1'b0;
      lsb_signed   <= 1'b0;
      lsb_len      <= '0;
      lsb_a        <= '0;
      lsb_din      <= '0;
    end else if (rdy_in) begin
      state        <= state_nxt;
      if_ack       <= if_ack_nxt;
      if_d         <= if_d_nxt;
      ls_ack       <= ls_ack_nxt;
      ls_dout      <= ls_dout_nxt;
      instr_signal <= instr_signal_nxt;
      instr_a      <= instr_a_nxt;
      lsb_signal   <= lsb_signal_nxt;
      lsb_wr       <= lsb_wr_nxt;
      lsb_signed   <= lsb_signed_nxt;
      lsb_len      <= lsb_len_nxt;
      lsb_a        <= lsb_a_nxt;
      lsb_din      <= lsb_din_nxt;
    end
  end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler with a manual and an automatic
// controller response path.
module tb_mem_req_scheduler;
  import mem_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_signal;
  logic        if_req;
  logic [31:0] if_a;
  logic        if_ack;
  logic [63:0] if_d;
  logic        ls_req, ls_wr, ls_signed;
  logic [1:0]  ls_len;
  logic [31:0] ls_a, ls_din;
  logic        ls_ack;
  logic [31:0] ls_dout;
  logic        instr_signal;
  logic [31:0] instr_a;
  logic [63:0] instr_d;
  logic        instr_done;
  logic        lsb_signal, lsb_wr, lsb_signed;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_a, lsb_din, lsb_dout;
  logic        lsb_done;
  logic        busy;

  // Controller stand-in: manual values or an automatic 2-cycle responder.
  logic        auto_en = 1'b0;
  logic        m_idone = 1'b0, m_ldone = 1'b0;
  logic [63:0] m_idata = '0;
  logic [31:0] m_ldata = '0;
  logic        a_idone = 1'b0, a_ldone = 1'b0;
  int unsigned a_icnt = 0, a_lcnt = 0;

  assign instr_done = auto_en ? a_idone : m_idone;
  assign lsb_done   = auto_en ? a_ldone : m_ldone;
  assign instr_d    = auto_en ? {32'hF00D_0000, instr_a} : m_idata;
  assign lsb_dout   = auto_en ? (lsb_a ^ 32'hA5A5_A5A5) : m_ldata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_req_scheduler #(
    .STARVE_MAX (4),
    .CNT_W      (3)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_signal (clear_signal),
    .if_req       (if_req),
    .if_a         (if_a),
    .if_ack       (if_ack),
    .if_d         (if_d),
    .ls_req       (ls_req),
    .ls_wr        (ls_wr),
    .ls_signed    (ls_signed),
    .ls_len       (ls_len),
    .ls_a         (ls_a),
    .ls_din       (ls_din),
    .ls_ack       (ls_ack),
    .ls_dout      (ls_dout),
    .instr_signal (instr_signal),
    .instr_a      (instr_a),
    .instr_d      (instr_d),
    .instr_done   (instr_done),
    .lsb_signal   (lsb_signal),
    .lsb_wr       (lsb_wr),
    .lsb_signed   (lsb_signed),
    .lsb_len      (lsb_len),
    .lsb_a        (lsb_a),
    .lsb_din      (lsb_din),
    .lsb_dout     (lsb_dout),
    .lsb_done     (lsb_done),
    .busy         (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Automatic responder: done rises after the signal has been high 2 cycles.
  always begin
    @(posedge clk_in);
    #1;
    if (instr_signal && !a_idone) begin
      a_icnt++;
      if (a_icnt >= 2) a_idone = 1'b1;
    end else begin
      a_idone = 1'b0;
      a_icnt  = 0;
    end
    if (lsb_signal && !a_ldone) begin
      a_lcnt++;
      if (a_lcnt >= 2) a_ldone = 1'b1;
    end else begin
      a_ldone = 1'b0;
      a_lcnt  = 0;
    end
  end

  logic [9:0] seq;
  int         n_gnt, both_cnt;
  logic       prev_i, prev_l;

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0;
    if_req = 1'b0; if_a = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_signed = 1'b0; ls_len = LEN_BYTE;
    ls_a = '0; ls_din = '0;
    tick(); tick();
    rst_in = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_isig", instr_signal, 0);
    check("rst_lsig", lsb_signal, 0);
    check("rst_acks", {if_ack, ls_ack}, 0);

    // Load with a latched address that must ignore requester changes.
    ls_req = 1'b1; ls_wr = 1'b0; ls_a = 32'h100; ls_len = LEN_WORD;
    tick();
    check("ld_grant", {lsb_signal, instr_signal, lsb_wr}, 3'b100);
    check("ld_addr", lsb_a, 32'h100);
    check("ld_len", lsb_len, LEN_WORD);
    ls_a = 32'h999;
    tick(); tick();
    check("ld_hold_sig", lsb_signal, 1);
    check("ld_hold_addr", lsb_a, 32'h100);
    check("ld_no_ack", ls_ack, 0);
    m_ldone = 1'b1; m_ldata = 32'hDEAD_BEEF;
    tick();
    check("ld_ack", {ls_ack, lsb_signal, busy}, 3'b101);
    check("ld_dout", ls_dout, 32'hDEAD_BEEF);
    ls_req = 1'b0; m_ldone = 1'b0;
    tick();
    check("ld_gap_end", {ls_ack, busy, lsb_signal}, 3'b000);

    // Plain fetch capturing both instructions.
    if_req = 1'b1; if_a = 32'h400;
    tick();
    check("if_grant", {instr_signal, lsb_signal}, 2'b10);
    check("if_addr", instr_a, 32'h400);
    m_idone = 1'b1; m_idata = 64'h1122_3344_5566_7788;
    tick();
    check("if_ack", {if_ack, instr_signal}, 2'b10);
    check("if_d", if_d, 64'h1122_3344_5566_7788);
    if_req = 1'b0; m_idone = 1'b0;
    tick();
    check("if_ack_pulse", if_ack, 0);

    // Clear in IF_WAIT; a late done during GAP is ignored.
    if_req = 1'b1; if_a = 32'h2000;
    tick();
    check("clr_if_grant", {instr_signal, instr_a}, {1'b1, 32'h2000});
    clear_signal = 1'b1;
    tick();
    check("clr_if_drop", {instr_signal, if_ack, busy}, 3'b001);
    clear_signal = 1'b0; if_req = 1'b0; m_idone = 1'b1;
    tick();
    check("clr_if_stale", {if_ack, busy, instr_signal}, 3'b000);
    m_idone = 1'b0;
    tick();
    check("clr_if_idle", {if_ack, busy, instr_signal}, 3'b000);

    // Clear in ST_WAIT does not abort the store.
    ls_req = 1'b1; ls_wr = 1'b1; ls_a = 32'h30000; ls_din = 32'h41; ls_len = LEN_BYTE;
    tick();
    check("st_grant", {lsb_signal, lsb_wr}, 2'b11);
    check("st_fields", {lsb_a, lsb_din}, {32'h30000, 32'h41});
    clear_signal = 1'b1;
    tick();
    check("st_clr_hold", {lsb_signal, ls_ack}, 2'b10);
    clear_signal = 1'b0; m_ldone = 1'b1;
    tick();
    check("st_ack", {ls_ack, lsb_signal}, 2'b10);
    ls_req = 1'b0; m_ldone = 1'b0; ls_wr = 1'b0;
    tick();
    tick();
    check("st_idle", {ls_ack, busy}, 2'b00);

    // rdy_in low freezes LD_WAIT even with done asserted.
    ls_req = 1'b1; ls_a = 32'h44; ls_len = LEN_WORD;
    tick();
    check("rdy_grant", lsb_signal, 1);
    rdy_in = 1'b0; m_ldone = 1'b1; m_ldata = 32'h1234_5678;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check("rdy_frozen", {lsb_signal, ls_ack, busy, lsb_a}, {3'b101, 32'h44});
    end
    rdy_in = 1'b1;
    tick();
    check("rdy_ack", {ls_ack, ls_dout}, {1'b1, 32'h1234_5678});
    m_ldone = 1'b0; ls_req = 1'b0;
    tick(); tick();

    // Reset in LD_WAIT abandons the transaction.
    ls_req = 1'b1; ls_a = 32'h88;
    tick();
    check("rstld_grant", lsb_signal, 1);
    rst_in = 1'b1; m_ldone = 1'b1; ls_req = 1'b0;
    tick();
    check("rstld_outs", {lsb_signal, ls_ack, busy, lsb_a, ls_dout}, '0);
    rst_in = 1'b0; m_ldone = 1'b0;
    tick();
    check("rstld_no_ack", {ls_ack, busy}, 2'b00);

    // Clear in IDLE blocks the grant for that cycle only.
    clear_signal = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_wr = 1'b0;
    tick();
    check("clr_idle_none", {instr_signal, lsb_signal, busy}, 3'b000);
    clear_signal = 1'b0;
    tick();
    check("clr_idle_lsb", {instr_signal, lsb_signal}, 2'b01);
    m_ldone = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    tick();
    m_ldone = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;

    // Contention with automatic controller: expect L L L L F L L L L F.
    auto_en = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_wr = 1'b0; ls_a = 32'h500;
    seq = '0; n_gnt = 0; both_cnt = 0; prev_i = 1'b0; prev_l = 1'b0;
    for (int unsigned c = 0; c < 300 && n_gnt < 10; c++) begin
      tick();
      if (instr_signal && lsb_signal) both_cnt++;
      if (instr_signal && !prev_i) begin seq[n_gnt] = 1'b1; n_gnt++; end
      else if (lsb_signal && !prev_l) begin seq[n_gnt] = 1'b0; n_gnt++; end
      prev_i = instr_signal;
      prev_l = lsb_signal;
    end
    check("cont_ngrant", n_gnt, 10);
    check("cont_order", seq, 10'b10_0001_0000);
    check("cont_onehot", both_cnt, 0);
    if_req = 1'b0; ls_req = 1'b0;
    tick(); tick(); tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_scheduler.md
Name: mem_req_scheduler

Overview:
- Sits between the requesters (instruction fetch / i-cache miss path, LSB) and memory_controller.
- Presents at most one request at a time to the controller and holds it stable until the matching done.
- Applies LSB-first priority with a starvation bound for fetch, and handles speculation clear.
- Returns results to the requester with a one-cycle ack pulse.

Parameters:
STARVE_MAX, 4, max consecutive LSB grants while if_req is pending before fetch is forced
CNT_W, 3, width of starvation counter (must hold STARVE_MAX)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  low = pause; all state and outputs hold
clear_signal  in  1  misprediction flush
if_req  in  1  fetch request level, held until if_ack
if_a  in  32  fetch address
if_ack  out  1  1-cycle pulse, if_d valid
if_d  out  64  two fetched instructions
ls_req  in  1  LSB request level, held until ls_ack
ls_wr  in  1  1 = store
ls_signed  in  1  signed load
ls_len  in  2  00 byte, 01 half, 11 word
ls_a  in  32  load/store address
ls_din  in  32  store data
ls_ack  out  1  1-cycle pulse, ls_dout valid for loads
ls_dout  out  32  load result
instr_signal  out  1  to controller
instr_a  out  32  to controller
instr_d  in  64  from controller
instr_done  in  1  from controller
lsb_signal  out  1  to controller
lsb_wr, lsb_signed  out  1 each  to controller
lsb_len  out  2  to controller
lsb_a, lsb_din  out  32 each  to controller
lsb_dout  in  32  from controller
lsb_done  in  1  from controller
busy  out  1  state != IDLE

Behaviour:
- Reset: state = IDLE; all outputs 0; starvation counter 0. Reset mid-transaction abandons it; no ack is issued.
- rdy_in low: no state, counter, or output changes.
- States: IDLE, IF_WAIT, LD_WAIT, ST_WAIT, GAP.
- IDLE: no grant in a cycle with clear_signal = 1.
  - Otherwise LSB wins if ls_req and (!if_req or cnt < STARVE_MAX). Else fetch wins if if_req.
  - On grant, latch the request fields into the output registers and assert the matching *_signal.
  - State after grant: fetch -> IF_WAIT; ls_wr = 1 -> ST_WAIT; ls_wr = 0 -> LD_WAIT.
  - Counter: LSB grant with if_req high -> cnt + 1, saturating at STARVE_MAX. Fetch grant -> cnt = 0. LSB grant with if_req low -> cnt = 0.
- IF_WAIT:
  - clear_signal -> drop instr_signal, no if_ack, go to GAP.
  - instr_done -> capture if_d = instr_d, pulse if_ack, drop instr_signal, go to GAP.
- LD_WAIT: same as IF_WAIT, using lsb_done, lsb_dout -> ls_dout, and ls_ack.
- ST_WAIT:
  - clear_signal is ignored; stores are committed.
  - lsb_done -> pulse ls_ack, drop lsb_signal, go to GAP.
  - Wait is unbounded (controller stalls on io_buffer_full).
- GAP: one cycle with both signals low, so the controller's done registers clear; then IDLE.
- Simultaneous clear and done in IF_WAIT/LD_WAIT: clear wins, no ack.
- Latched request outputs stay constant from grant until signal deassert; requester changes to if_*/ls_* during that window are ignored.
- *_signal outputs are registered; minimum latency from grant to ack is controller latency + 1.
- At most one of instr_signal / lsb_signal is high in any cycle.
- Requesters must drop req the cycle after ack. If a req is still high in IDLE, it is treated as a new request.

Decomposition:
- Shared package (mem_pkg): state encoding constants, LEN_BYTE/HALF/WORD encodings, CNT_W default.
- One sub-module is natural: mem_grant_arbiter, the combinational priority plus starvation counter register, reusable for a future d-cache port.

Test Plan:
- Load only: ls_req, ls_wr = 0, ls_a = 0x100, ls_len = 11; controller model returns 0xDEADBEEF -> lsb_signal held until lsb_done, ls_ack 1 cycle with ls_dout = 0xDEADBEEF, then one GAP cycle.
- Contention: if_req and ls_req continuously high, STARVE_MAX = 4 -> grant order is L, L, L, L, F, L, L, L, L, F; never two signals high at once.
- Clear during fetch: clear_signal pulses in IF_WAIT at if_a = 0x2000 -> instr_signal low next cycle, no if_ack, GAP then IDLE; a stale instr_done one cycle later is ignored.
- Clear during store: ls_wr = 1, ls_a = 0x30000, ls_din = 0x41, clear in ST_WAIT -> lsb_signal stays high, ls_ack pulses on lsb_done.
- rdy_in low for 5 cycles in LD_WAIT -> outputs frozen, completion proceeds afterwards; reset asserted in LD_WAIT -> all outputs 0 next cycle, no ls_ack.
- Clear in IDLE with both reqs high -> no grant that cycle; LSB is granted the next cycle.
